modulus_down_counter: RTL and testbench
=======================================

Name: modulus_down_counter

Overview:
- Down-counting companion to the team's programmable-limit up counter (counts 0..limit, wraps to 0).
- Counts limit, limit-1, ..., 0, then reloads limit.
- Provides synchronous load, count enable, a registered wrap pulse and a saturating wrap tally.
- Used as a programmable divider / timeout source next to the up counter in the counters library.

Parameters:
- n, 3, width of count, limit and load value.
- W_WRAP, 8, width of saturating wrap tally.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; counter holds when low.
- load  input  1  synchronous load strobe; priority over en.
- load_val  input  n  value loaded when load=1.
- limit  input  n  modulus-1; reload value after reaching 0.
- Q  output  n  current count (registered).
- zero  output  1  combinational, Q==0.
- tc  output  1  registered one-cycle pulse, high the cycle after a wrap.
- wraps  output  W_WRAP  registered count of wraps, saturating at all-ones.

Behaviour:
- Reset, asserted async at any time including mid-count:
  - Q=0, tc=0, wraps=0 immediately.
  - zero=1 while in reset.
- Deassertion is sampled synchronously at the next rising edge; no count on that edge unless en/load is already high.
- Per-edge priority when reset_n=1:
  1. load=1: Q<=min(load_val, limit), using the live limit. No wrap, tc<=0, wraps unchanged. Applies regardless of en.
  2. else en=1 and Q!=0: Q<=Q-1, tc<=0.
  3. else en=1 and Q==0 (wrap event): Q<=limit (sampled this edge), tc<=1, wraps<=wraps+1 unless already all-ones.
  4. else (en=0): Q holds, tc<=0, wraps holds.
- Timing:
  - tc is high exactly one cycle per wrap.
  - Back-to-back wraps give continuous tc.
  - tc latency: high in the cycle where Q first shows the reloaded limit.
- Limit handling:
  - limit is sampled only on a wrap or a load clamp.
  - Changing limit mid-count does not alter the current Q; the new value takes effect at the next reload.
  - limit==0: Q stays 0, and every enabled cycle is a wrap (tc high continuously, wraps increments each enabled cycle).
  - limit=all-ones: full 2^n-cycle period. No width growth: Q-1 is never evaluated at Q=0.
- Period: with en held high and limit constant, the wrap period is limit+1 cycles.
- Clamp: load_val>limit loads limit, not load_val.
- Simultaneous load and Q==0 with en=1: load wins, no wrap is counted.
- All state uses nonblocking assignments. The next-state block is fully combinational with default assignments (no latches).

Decomposition:
- Shared counters package:
  - no typedefs needed;
  - holds a localparam for the tally saturation value, computed as all-ones of W_WRAP.
- Sub-module sat_counter (parameter W):
  - ports clk, reset_n, inc, out;
  - increments on inc and saturates at all-ones;
  - instantiated for wraps.
- Q/tc next-state logic stays inline.

Test Plan:
- Reset then en=1, limit=5 → Q: 0,5,4,3,2,1,0,5. tc high in each cycle Q shows 5 after a 0, so period 6. wraps increments 0→1→2.
- Mid-count limit change: limit=5, at Q=3 set limit=2 → Q: 3,2,1,0,2,1,0,2. First reload uses the new limit=2.
- load priority and clamp:
  - limit=4, load=1, load_val=6, en=0 → Q=4 next cycle, tc=0.
  - load_val=2 with en=1 at Q=0 → Q=2, no tc, wraps unchanged.
- limit=0, en=1 for 5 cycles → Q stays 0, zero=1, tc high all 5 following cycles, wraps=5.
- Saturation, W_WRAP=2, limit=0: en for 6 cycles → wraps 1,2,3,3,3,3. No rollover.
- Async reset: assert reset_n=0 mid-count (Q=3, wraps=2) between edges → Q=0, tc=0, wraps=0 before the next edge. After release with en=1, limit=7 → Q goes 0→7 with tc.

Source files
------------

// File: rtl/modulus_down_counter_pkg.sv
// Shared constants for the counters library.
//   W_WRAP_DEFAULT : default width of the wrap tally
//   SAT_ALL_ONES   : all-ones source from which a W-bit tally takes its saturation value
package modulus_down_counter_pkg;

   localparam int unsigned W_WRAP_DEFAULT = 8;

   // Wide all-ones; a tally of width W saturates at SAT_ALL_ONES[W-1:0] (W <= 64).
   localparam logic [63:0] SAT_ALL_ONES = '1;

endpackage

// File: rtl/modulus_down_counter_sat_counter.sv
// Saturating up counter used as the wrap tally.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears the count
//   inc     : increment request for this edge
//   out     : registered count, sticks at all-ones
module sat_counter
   import modulus_down_counter_pkg::*;
#(
   parameter int unsigned W = W_WRAP_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   output logic [W-1:0] out
);

   localparam logic [W-1:0] SAT = SAT_ALL_ONES[W-1:0];

   logic [W-1:0] out_d;

   always_comb begin
      out_d = out;
      if (inc && (out != SAT)) begin
         out_d = out + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out <= '0;
      end else begin
         out <= out_d;
      end
   end

endmodule

// File: rtl/modulus_down_counter.sv
// Programmable-modulus down counter: counts limit..0, then reloads limit.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   en       : count enable; counter holds when low
//   load     : synchronous load strobe, wins over en
//   load_val : value loaded on load, clamped to limit
//   limit    : modulus-1; reload value after reaching 0
//   Q        : registered count
//   zero     : combinational Q==0
//   tc       : registered pulse, high in the cycle Q shows a reloaded limit
//   wraps    : saturating count of wrap events
module modulus_down_counter
   import modulus_down_counter_pkg::*;
#(
   parameter int unsigned n      = 3,
   parameter int unsigned W_WRAP = W_WRAP_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              load,
   input  logic [n-1:0]      load_val,
   input  logic [n-1:0]      limit,
   output logic [n-1:0]      Q,
   output logic              zero,
   output logic              tc,
   output logic [W_WRAP-1:0] wraps
);

   logic [n-1:0] q_d;
   logic         tc_d;
   logic         wrap;

   assign zero = (Q == '0);

   always_comb begin
      q_d  = Q;
      tc_d = 1'b0;
      wrap = 1'b0;
      if (load) begin
         // limit is only sampled here and on a wrap.
         q_d = (load_val > limit) ? limit : load_val;
      end else if (en) begin
         if (Q != '0) begin
            q_d = Q - n'(1);
         end else begin
            // Decrement is never taken at Q==0, so no underflow handling is needed.
            q_d  = limit;
            tc_d = 1'b1;
            wrap = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         Q  <= '0;
         tc <= 1'b0;
      end else begin
         Q  <= q_d;
         tc <= tc_d;
      end
   end

   sat_counter #(
      .W (W_WRAP)
   ) u_wrap_tally (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (wrap),
      .out     (wraps)
   );

endmodule

// File: tb/tb_modulus_down_counter.sv
module tb_modulus_down_counter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [2:0] load_val = '0;
   logic [2:0] limit = '0;
   logic [2:0] q;
   logic       zero;
   logic       tc;
   logic [7:0] wraps;
   logic [2:0] q2;
   logic       zero2;
   logic       tc2;
   logic [1:0] wraps2;

   int checks = 0;
   int errors = 0;

   // Behavioural reference state
   int m_q, m_tc, m_w, m_w2;

   always #5 clk = ~clk;

   modulus_down_counter #(.n(3), .W_WRAP(8)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .load(load), .load_val(load_val),
      .limit(limit), .Q(q), .zero(zero), .tc(tc), .wraps(wraps)
   );

   modulus_down_counter #(.n(3), .W_WRAP(2)) dut_sat (
      .clk(clk), .reset_n(reset_n), .en(en), .load(load), .load_val(load_val),
      .limit(limit), .Q(q2), .zero(zero2), .tc(tc2), .wraps(wraps2)
   );

   typedef struct {
      bit ld;
      bit e;
      int lv;
      int lim;
      int xq;
      int xtc;
      int xw;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      m_q = 0; m_tc = 0; m_w = 0; m_w2 = 0;
   endtask

   // Next state from the behavioural rules, using the inputs present before the edge.
   task automatic model_step();
      if (load) begin
         m_q  = min2(int'(load_val), int'(limit));
         m_tc = 0;
      end else if (en) begin
         if (m_q == 0) begin
            m_q  = int'(limit);
            m_tc = 1;
            m_w  = min2(m_w + 1, 255);
            m_w2 = min2(m_w2 + 1, 3);
         end else begin
            m_q  = m_q - 1;
            m_tc = 0;
         end
      end else begin
         m_tc = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      en = 1'b0; load = 1'b0; load_val = '0; limit = '0;
      #2;
      chk("reset_q", int'(q), 0);
      chk("reset_tc", int'(tc), 0);
      chk("reset_wraps", int'(wraps), 0);
      chk("reset_zero", int'(zero), 1);
      tick();
      reset_n = 1'b1;
      model_reset();
   endtask

   vec_t tab[$];

   initial begin
      tab = '{
         '{0,1,0,5, 5,1,1}, '{0,1,0,5, 4,0,1}, '{0,1,0,5, 3,0,1}, '{0,1,0,5, 2,0,1},
         '{0,1,0,5, 1,0,1}, '{0,1,0,5, 0,0,1}, '{0,1,0,5, 5,1,2}, '{0,1,0,5, 4,0,2},
         '{0,1,0,5, 3,0,2},
         // limit drops to 2 mid-count
         '{0,1,0,2, 2,0,2}, '{0,1,0,2, 1,0,2}, '{0,1,0,2, 0,0,2}, '{0,1,0,2, 2,1,3},
         '{0,1,0,2, 1,0,3}, '{0,1,0,2, 0,0,3}, '{0,1,0,2, 2,1,4},
         // load clamp, then load wins over a pending wrap
         '{1,0,6,4, 4,0,4}, '{0,1,0,4, 3,0,4}, '{0,1,0,4, 2,0,4}, '{0,1,0,4, 1,0,4},
         '{0,1,0,4, 0,0,4}, '{1,1,2,4, 2,0,4},
         // hold with en low, even across a limit change
         '{0,0,0,4, 2,0,4}, '{0,0,0,7, 2,0,4},
         '{1,0,5,3, 3,0,4}, '{1,0,1,3, 1,0,4},
         '{0,1,0,7, 0,0,4}, '{0,1,0,7, 7,1,5}, '{0,1,0,7, 6,0,5}, '{0,0,0,7, 6,0,5}
      };

      do_reset();

      // Table-driven directed sequence
      foreach (tab[i]) begin
         load = tab[i].ld; en = tab[i].e;
         load_val = 3'(tab[i].lv); limit = 3'(tab[i].lim);
         tick();
         chk($sformatf("tab%0d_q", i), int'(q), tab[i].xq);
         chk($sformatf("tab%0d_tc", i), int'(tc), tab[i].xtc);
         chk($sformatf("tab%0d_wraps", i), int'(wraps), tab[i].xw);
         chk($sformatf("tab%0d_zero", i), int'(zero), (tab[i].xq == 0) ? 1 : 0);
         chk($sformatf("tab%0d_wraps_sat", i), int'(wraps2), min2(tab[i].xw, 3));
      end

      // limit==0: every enabled cycle wraps; 2-bit tally saturates at 3
      do_reset();
      en = 1'b1; limit = 3'd0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("lim0_%0d_q", k), int'(q), 0);
         chk($sformatf("lim0_%0d_zero", k), int'(zero), 1);
         chk($sformatf("lim0_%0d_tc", k), int'(tc), 1);
         chk($sformatf("lim0_%0d_wraps", k), int'(wraps), k);
         chk($sformatf("lim0_%0d_wraps_sat", k), int'(wraps2), min2(k, 3));
      end

      // Async reset between edges at Q=3, wraps=2
      do_reset();
      en = 1'b1; limit = 3'd5;
      for (int k = 0; k < 9; k++) tick();
      chk("pre_async_q", int'(q), 3);
      chk("pre_async_wraps", int'(wraps), 2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_q", int'(q), 0);
      chk("async_tc", int'(tc), 0);
      chk("async_wraps", int'(wraps), 0);
      chk("async_zero", int'(zero), 1);
      tick();
      chk("async_hold_q", int'(q), 0);
      // Release with en low: no count on the next edge
      en = 1'b0; reset_n = 1'b1;
      tick();
      chk("rel_idle_q", int'(q), 0);
      chk("rel_idle_tc", int'(tc), 0);
      en = 1'b1; limit = 3'd7;
      tick();
      chk("rel_q", int'(q), 7);
      chk("rel_tc", int'(tc), 1);
      chk("rel_wraps", int'(wraps), 1);
      tick();
      chk("rel2_q", int'(q), 6);
      chk("rel2_tc", int'(tc), 0);

      // Randomized run against the reference model
      do_reset();
      for (int k = 0; k < 400; k++) begin
         load = ($urandom_range(7) == 0);
         en = ($urandom_range(3) != 0);
         load_val = 3'($urandom_range(7));
         case ($urandom_range(9))
            0: limit = 3'd0;
            1: limit = 3'd7;
            2, 3, 4, 5: limit = limit;
            default: limit = 3'($urandom_range(7));
         endcase
         model_step();
         tick();
         chk("rnd_q", int'(q), m_q);
         chk("rnd_tc", int'(tc), m_tc);
         chk("rnd_zero", int'(zero), (m_q == 0) ? 1 : 0);
         chk("rnd_wraps", int'(wraps), m_w);
         chk("rnd_wraps_sat", int'(wraps2), m_w2);
         chk("rnd_q_sat", int'(q2), m_q);
         chk("rnd_tc_sat", int'(tc2), m_tc);
         chk("rnd_zero_sat", int'(zero2), (m_q == 0) ? 1 : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
